// File: rtl/motor_pkg.sv
// Shared motor-control types: step generator FSM states and default step timing.
package motor_pkg;

   typedef enum logic [1:0] {
      STEP_IDLE,
      STEP_SETUP,
      STEP_HIGH,
      STEP_LOW
   } step_state_e;

   localparam int DEF_PULSE_HIGH = 8;
   localparam int DEF_DIR_SETUP  = 16;

endpackage

// File: rtl/step_pulse_gen_if.sv
// Host <-> step generator bundle: move command handshake, abort, driver outputs and status.
interface step_pulse_gen_if #(
   parameter int COUNT_W  = 16,
   parameter int PERIOD_W = 20
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [COUNT_W-1:0]  cmd_steps;
   logic                cmd_dir;
   logic [PERIOD_W-1:0] cmd_period;
   logic                abort;
   logic                rotate_pulse;
   logic                direction;
   logic                module_enable;
   logic                busy;
   logic                done;
   logic [COUNT_W-1:0]  steps_left;

   modport master (
      output cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
      input  cmd_ready, rotate_pulse, direction, module_enable, busy, done, steps_left
   );

   modport slave (
      input  cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
      output cmd_ready, rotate_pulse, direction, module_enable, busy, done, steps_left
   );
endinterface

// File: rtl/step_ramp.sv
// Trapezoidal period profile for the step generator; only built when STEP_RAMP_EN is defined.
`ifdef STEP_RAMP_EN
module step_ramp #(
   parameter int COUNT_W  = 16,
   parameter int PERIOD_W = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_load,
   input  logic                i_advance,
   input  logic [PERIOD_W-1:0] i_start,
   input  logic [PERIOD_W-1:0] i_step,
   input  logic [PERIOD_W-1:0] i_target,
   input  logic [COUNT_W-1:0]  i_steps_left,
   output logic [PERIOD_W-1:0] o_period
);
   logic [PERIOD_W-1:0] r_period;
   logic [COUNT_W-1:0]  r_accel;
   logic [PERIOD_W-1:0] w_ceiling;
   logic [PERIOD_W:0]   w_up;
   logic [PERIOD_W-1:0] w_down;

   assign w_ceiling = (i_start > i_target) ? i_start : i_target;
   assign w_up      = {1'b0, r_period} + {1'b0, i_step};
   assign w_down    = ((r_period - i_target) > i_step) ? (r_period - i_step) : i_target;

   // Deceleration mirrors acceleration: once the remaining steps fit in the
   // accelerating count, climb back towards the starting period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period <= '0;
         r_accel  <= '0;
      end else if (i_load) begin
         r_period <= w_ceiling;
         r_accel  <= '0;
      end else if (i_advance) begin
         if (i_steps_left <= r_accel) begin
            r_period <= (w_up >= {1'b0, w_ceiling}) ? w_ceiling : w_up[PERIOD_W-1:0];
         end else if (r_period > i_target) begin
            r_period <= w_down;
            r_accel  <= r_accel + COUNT_W'(1);
         end
      end
   end

   assign o_period = r_period;
endmodule
`endif

// File: rtl/step_pulse_gen.sv
// Command-driven step/direction generator for the stepper driver; all outputs registered.
// STEP_RAMP_EN adds a trapezoidal period ramp through step_ramp.
module step_pulse_gen
   import motor_pkg::*;
#(
   parameter int COUNT_W    = 16,
   parameter int PERIOD_W   = 20,
   parameter int PULSE_HIGH = DEF_PULSE_HIGH,
   parameter int DIR_SETUP  = DEF_DIR_SETUP
`ifdef STEP_RAMP_EN
   ,
   parameter logic [PERIOD_W-1:0] RAMP_START = 20'd200000,
   parameter logic [PERIOD_W-1:0] RAMP_STEP  = 20'd1000
`endif
) (
   input  logic           clk,
   input  logic           rst_n,
   step_pulse_gen_if.slave bus
);
   localparam logic [PERIOD_W-1:0] C_PH         = PERIOD_W'(PULSE_HIGH);
   localparam logic [PERIOD_W-1:0] C_PH_LAST    = PERIOD_W'(PULSE_HIGH - 1);
   localparam logic [PERIOD_W-1:0] C_MIN_PERIOD = PERIOD_W'(2 * PULSE_HIGH);
   localparam logic [PERIOD_W-1:0] C_SETUP_LAST = PERIOD_W'(DIR_SETUP - 1);

   step_state_e         r_state, w_state_nxt;
   logic [PERIOD_W-1:0] r_cnt, w_cnt_nxt;
   logic [COUNT_W-1:0]  r_steps, w_steps_nxt;
   logic [PERIOD_W-1:0] r_period, w_period_nxt;
   logic [PERIOD_W-1:0] r_pulse_per, w_pulse_per_nxt;
   logic                r_abort_seen, w_abort_nxt;
   logic                r_dir, w_dir_nxt;
   logic                r_rot, w_rot_nxt;
   logic                r_done, w_done_nxt;
   logic                r_busy;
   logic                r_ready;
   logic                w_accept;
   logic                w_advance;
   logic                w_enter_high;
   logic [PERIOD_W-1:0] w_raw_period;
   logic [PERIOD_W-1:0] w_eff_period;

`ifdef STEP_RAMP_EN
   logic [PERIOD_W-1:0] w_ramp_period;
   logic [PERIOD_W-1:0] w_ramp_target;

   assign w_ramp_target = w_accept ? bus.cmd_period : r_period;

   step_ramp #(
      .COUNT_W  (COUNT_W),
      .PERIOD_W (PERIOD_W)
   ) u_ramp (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_load       (w_accept),
      .i_advance    (w_advance),
      .i_start      (RAMP_START),
      .i_step       (RAMP_STEP),
      .i_target     (w_ramp_target),
      .i_steps_left (r_steps),
      .o_period     (w_ramp_period)
   );
   assign w_raw_period = w_ramp_period;
`else
   assign w_raw_period = r_period;
`endif

   // Low time never shorter than the high time.
   assign w_eff_period = (w_raw_period < C_MIN_PERIOD) ? C_MIN_PERIOD : w_raw_period;

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_steps_nxt     = r_steps;
      w_period_nxt    = r_period;
      w_pulse_per_nxt = r_pulse_per;
      w_abort_nxt     = r_abort_seen;
      w_dir_nxt       = r_dir;
      w_rot_nxt       = 1'b0;
      w_done_nxt      = 1'b0;
      w_accept        = 1'b0;
      w_advance       = 1'b0;
      w_enter_high    = 1'b0;

      case (r_state)
         STEP_IDLE: begin
            w_accept = bus.cmd_valid;
         end
         STEP_SETUP: begin
            if (bus.abort) begin
               w_state_nxt = STEP_IDLE;
               w_done_nxt  = 1'b1;
            end else if (r_cnt == '0) begin
               w_enter_high = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - PERIOD_W'(1);
            end
         end
         STEP_HIGH: begin
            w_abort_nxt = r_abort_seen | bus.abort;
            w_advance   = (r_cnt == '0);
            if (w_advance) begin
               w_state_nxt = STEP_LOW;
               w_cnt_nxt   = r_pulse_per - C_PH - PERIOD_W'(1);
            end else begin
               w_rot_nxt = 1'b1;
               w_cnt_nxt = r_cnt - PERIOD_W'(1);
            end
         end
         STEP_LOW: begin
            w_abort_nxt = r_abort_seen | bus.abort;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - PERIOD_W'(1);
            end else if ((r_steps != '0) && !(r_abort_seen | bus.abort)) begin
               w_enter_high = 1'b1;
            end else begin
               w_state_nxt = STEP_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = STEP_IDLE;
         end
      endcase

      if (w_accept) begin
         w_steps_nxt  = bus.cmd_steps;
         w_dir_nxt    = bus.cmd_dir;
         w_period_nxt = bus.cmd_period;
         w_abort_nxt  = 1'b0;
         if (bus.cmd_steps == '0) begin
            w_done_nxt = 1'b1;
         end else begin
            w_state_nxt = STEP_SETUP;
            w_cnt_nxt   = C_SETUP_LAST;
         end
      end

      // The period is frozen per pulse so a ramp update cannot stretch the current low time.
      if (w_enter_high) begin
         w_state_nxt     = STEP_HIGH;
         w_cnt_nxt       = C_PH_LAST;
         w_steps_nxt     = r_steps - COUNT_W'(1);
         w_pulse_per_nxt = w_eff_period;
         w_rot_nxt       = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= STEP_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_steps      <= '0;
         r_period     <= '0;
         r_pulse_per  <= '0;
         r_abort_seen <= 1'b0;
         r_dir        <= 1'b0;
         r_rot        <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_ready      <= 1'b1;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_steps      <= w_steps_nxt;
         r_period     <= w_period_nxt;
         r_pulse_per  <= w_pulse_per_nxt;
         r_abort_seen <= w_abort_nxt;
         r_dir        <= w_dir_nxt;
         r_rot        <= w_rot_nxt;
         r_done       <= w_done_nxt;
         r_busy       <= (w_state_nxt != STEP_IDLE);
         r_ready      <= (w_state_nxt == STEP_IDLE);
      end
   end

   assign bus.cmd_ready     = r_ready;
   assign bus.rotate_pulse  = r_rot;
   assign bus.direction     = r_dir;
   assign bus.module_enable = r_busy;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.steps_left    = r_steps;
endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen: command table plus reset, back-to-back and ramp sequences.
`timescale 1ns/1ps
module tb_step_pulse_gen;
   localparam int COUNT_W  = 16;
   localparam int PERIOD_W = 20;
   localparam int PH       = 8;
   localparam int DS       = 16;
   localparam int FIRST    = DS + 1;  // first rise, in cycles after the accepting cycle
   localparam int BUDGET   = 20000;
   localparam int NVEC     = 7;

   // abort_at: 0 none, k>0 abort during pulse k, -1 abort during direction setup
   typedef struct {
      int steps;
      int dir;
      int period;
      int abort_at;
      int exp_busy;
      int exp_pulses;
      int exp_gap;
      int exp_done;
      int exp_left;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rise_cnt = 0;
   int   rise_cyc = 0;
   int   done_cnt = 0;
   int   cur_vec = 0;
   bit   busy_seen = 1'b0;
   int   exp_rise[$];
   int   exp_done[$];
   vec_t vecs[NVEC];

   always #5 clk = ~clk;

   step_pulse_gen_if #(.COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W)) sif ();

   step_pulse_gen #(
`ifdef STEP_RAMP_EN
      .RAMP_START (20'd1000),
      .RAMP_STEP  (20'd100),
`endif
      .COUNT_W    (COUNT_W),
      .PERIOD_W   (PERIOD_W),
      .PULSE_HIGH (PH),
      .DIR_SETUP  (DS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (seq %0d): got %0d, want %0d at cycle %0d", name, cur_vec, act, exp, cyc);
      end
   endtask

   initial begin : cycle_counter
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Scoreboard side: every rise and every done pops its expected cycle.
   initial begin : monitor
      bit prev_rot;
      prev_rot = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rot = 1'b0;
         end else begin
            if (sif.busy) busy_seen = 1'b1;
            if (sif.rotate_pulse && !prev_rot) begin
               rise_cnt++;
               rise_cyc = cyc;
               if (exp_rise.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rise (seq %0d): pulse at cycle %0d, none expected", cur_vec, cyc);
               end else begin
                  chk("rise_cycle", cyc, exp_rise.pop_front());
               end
            end
            if (!sif.rotate_pulse && prev_rot) chk("high_time", cyc - rise_cyc, PH);
            if (sif.done) begin
               done_cnt++;
               chk("ready_with_done", sif.cmd_ready, 1);
               if (exp_done.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done (seq %0d): done at cycle %0d, none expected", cur_vec, cyc);
               end else begin
                  chk("done_cycle", cyc, exp_done.pop_front());
               end
            end
            prev_rot = sif.rotate_pulse;
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // Called at a negedge; returns the accepting cycle and leaves just after the accepting edge.
   task automatic issue(input int steps, input int dir, input int period, output int t);
      int n;
      n = 0;
      while (!sif.cmd_ready && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_cmd", sif.cmd_ready, 1);
      sif.cmd_valid  = 1'b1;
      sif.cmd_steps  = COUNT_W'(steps);
      sif.cmd_dir    = dir[0];
      sif.cmd_period = PERIOD_W'(period);
      t = cyc;
      @(posedge clk);
      #1;
      sif.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!sif.done && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!sif.done) begin
         errors++;
         $display("FAIL %s: done not seen within %0d cycles", name, n);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int t, r0, n;
      r0 = rise_cnt;
      busy_seen = 1'b0;
      issue(v.steps, v.dir, v.period, t);
      for (int i = 0; i < v.exp_pulses; i++) exp_rise.push_back(t + FIRST + i * v.exp_gap);
      exp_done.push_back(t + v.exp_done);
      @(negedge clk);
      chk("busy_after_accept", sif.busy, v.exp_busy);
      chk("enable_after_accept", sif.module_enable, v.exp_busy);
      if (v.abort_at > 0) begin
         n = 0;
         while (rise_cnt < r0 + v.abort_at && n < BUDGET) begin
            @(posedge clk);
            n++;
         end
         @(negedge clk);
         sif.abort = 1'b1;
         @(negedge clk);
         sif.abort = 1'b0;
      end else if (v.abort_at < 0) begin
         @(negedge clk);
         @(negedge clk);
         sif.abort = 1'b1;
         @(negedge clk);
         sif.abort = 1'b0;
      end
      wait_done("done_timeout");
      repeat (3) @(negedge clk);
      chk("pulse_count", rise_cnt - r0, v.exp_pulses);
      chk("rises_pending", exp_rise.size(), 0);
      chk("steps_left", sif.steps_left, v.exp_left);
      chk("direction", sif.direction, v.dir);
      chk("busy_idle", sif.busy, 0);
      if (v.exp_busy == 0) chk("busy_never", busy_seen, 0);
   endtask

`ifdef STEP_RAMP_EN
   int gaps[8] = '{1000, 900, 800, 700, 700, 800, 900, 1000};
`endif

   initial begin : stim
      int t, ta, tb, d, r0, n, acc;
      sif.cmd_valid  = 1'b0;
      sif.cmd_steps  = '0;
      sif.cmd_dir    = 1'b0;
      sif.cmd_period = '0;
      sif.abort      = 1'b0;

      //         steps dir period abort busy pulses gap  done left
      vecs[0] = '{3,    1,  100,   0,    1,   3,    100, 317, 0};
      vecs[1] = '{0,    0,  100,   0,    0,   0,    0,   1,   0};
      vecs[2] = '{10,   1,  50,    4,    1,   4,    50,  217, 6};
      vecs[3] = '{2,    0,  5,     0,    1,   2,    16,  49,  0};
      vecs[4] = '{4,    1,  16,    0,    1,   4,    16,  81,  0};
      vecs[5] = '{5,    0,  40,    -1,   1,   0,    0,   4,   5};
      vecs[6] = '{1,    1,  17,    0,    1,   1,    17,  34,  0};

      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", sif.cmd_ready, 1);
      chk("rst_rotate_pulse", sif.rotate_pulse, 0);
      chk("rst_direction", sif.direction, 0);
      chk("rst_module_enable", sif.module_enable, 0);
      chk("rst_busy", sif.busy, 0);
      chk("rst_done", sif.done, 0);
      chk("rst_steps_left", sif.steps_left, 0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef STEP_RAMP_EN
      cur_vec = 200;
      r0 = rise_cnt;
      issue(8, 1, 700, t);
      acc = t + FIRST;
      for (int i = 0; i < 8; i++) begin
         exp_rise.push_back(acc);
         acc += gaps[i];
      end
      exp_done.push_back(acc);
      wait_done("ramp_done_timeout");
      repeat (3) @(negedge clk);
      chk("ramp_pulse_count", rise_cnt - r0, 8);
      chk("ramp_rises_pending", exp_rise.size(), 0);
      chk("ramp_steps_left", sif.steps_left, 0);
`else
      for (int i = 0; i < NVEC; i++) begin
         cur_vec = i;
         run_vec(vecs[i]);
      end

      // Back-to-back: second command offered in the done cycle.
      cur_vec = 100;
      r0 = rise_cnt;
      issue(1, 1, 16, ta);
      exp_rise.push_back(ta + FIRST);
      exp_done.push_back(ta + FIRST + 16);
      wait_done("b2b_first_timeout");
      issue(2, 0, 16, tb);
      chk("b2b_accept_cycle", tb, ta + FIRST + 16);
      exp_rise.push_back(tb + FIRST);
      exp_rise.push_back(tb + FIRST + 16);
      exp_done.push_back(tb + FIRST + 32);
      wait_done("b2b_second_timeout");
      repeat (3) @(negedge clk);
      chk("b2b_pulse_count", rise_cnt - r0, 3);
      chk("b2b_direction", sif.direction, 0);

      // Reset in the middle of a high phase.
      cur_vec = 101;
      r0 = rise_cnt;
      issue(5, 1, 100, t);
      exp_rise.push_back(t + FIRST);
      n = 0;
      while (rise_cnt == r0 && n < BUDGET) begin
         @(posedge clk);
         n++;
      end
      chk("reset_test_pulse", rise_cnt, r0 + 1);
      @(posedge clk);
      #3;
      d = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("reset_rotate_pulse", sif.rotate_pulse, 0);
      chk("reset_busy", sif.busy, 0);
      chk("reset_enable", sif.module_enable, 0);
      chk("reset_ready", sif.cmd_ready, 1);
      chk("reset_steps_left", sif.steps_left, 0);
      exp_rise.delete();
      exp_done.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("no_done_after_reset", done_cnt, d);
      chk("no_pulse_after_reset", rise_cnt, r0 + 1);
      cur_vec = 0;
      run_vec(vecs[0]);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
